// File: rtl/tb_pzcorebus_slave_bfm_if.sv
// pzcorebus command / write-data / response channel bundle.
// The slave modport is the responder's view; the master modport drives commands and data.
interface tb_pzcorebus_slave_bfm_if #(
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LENGTH_WIDTH = 5,
  parameter int unsigned DATA_WIDTH   = 64
);
  // Command channel
  logic                      i_mcmd_valid;
  logic                      o_scmd_accept;
  logic [1:0]                i_mcmd;
  logic [ID_WIDTH-1:0]       i_mid;
  logic [ADDR_WIDTH-1:0]     i_maddr;
  logic [LENGTH_WIDTH-1:0]   i_mlength;
  // Write data channel
  logic                      i_mdata_valid;
  logic                      o_sdata_accept;
  logic [DATA_WIDTH-1:0]     i_mdata;
  logic [DATA_WIDTH/8-1:0]   i_mdata_byteen;
  logic                      i_mdata_last;
  // Response channel
  logic                      o_sresp_valid;
  logic                      i_mresp_accept;
  logic                      o_sresp;
  logic [ID_WIDTH-1:0]       o_sid;
  logic                      o_serror;
  logic [DATA_WIDTH-1:0]     o_sdata;
  logic                      o_sresp_last;

  modport slave (
    input  i_mcmd_valid, i_mcmd, i_mid, i_maddr, i_mlength,
    input  i_mdata_valid, i_mdata, i_mdata_byteen, i_mdata_last,
    input  i_mresp_accept,
    output o_scmd_accept, o_sdata_accept,
    output o_sresp_valid, o_sresp, o_sid, o_serror, o_sdata, o_sresp_last
  );

  modport master (
    output i_mcmd_valid, i_mcmd, i_mid, i_maddr, i_mlength,
    output i_mdata_valid, i_mdata, i_mdata_byteen, i_mdata_last,
    output i_mresp_accept,
    input  o_scmd_accept, o_sdata_accept,
    input  o_sresp_valid, o_sresp, o_sid, o_serror, o_sdata, o_sresp_last
  );
endinterface

// File: rtl/tb_pzcorebus_slave_bfm.sv
// pzcorebus responder BFM: command FIFO, behavioural memory, in-order responses.
// Optional feature macro: PZCOREBUS_SLAVE_BFM_RANDOM_STALL_EN (LFSR-driven accept/response stalls).
module tb_pzcorebus_slave_bfm #(
  parameter int unsigned ID_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LENGTH_WIDTH = 5,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned RESP_GAP     = 0
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  tb_pzcorebus_slave_bfm_if.slave bus_io
);
  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = ADDR_WIDTH - OffW;
  localparam int unsigned PtrW  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned CntW  = LENGTH_WIDTH + 1;
  localparam int unsigned MaW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] CmdWrite = 2'b01;
  localparam logic [1:0] CmdWnp   = 2'b10;
  localparam logic [1:0] CmdRsvd  = 2'b11;

  typedef enum logic [1:0] {StIdle, StWriteData, StReadResp, StWriteResp} state_e;

  typedef struct packed {
    logic [1:0]              cmd;
    logic [ID_WIDTH-1:0]     id;
    logic [IdxW-1:0]         idx;
    logic [LENGTH_WIDTH-1:0] len;
  } cmd_t;

  function automatic logic [MaW-1:0] wrap_idx(input logic [IdxW-1:0] i);
    return MaW'(i % IdxW'(MEM_WORDS));
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(CMD_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  state_e                  state_q, state_d;
  logic                    ready_q;
  cmd_t                    fifo_q [CMD_DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]           count_q, count_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CntW-1:0]         len_q, len_d, cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [15:0]             gap_q, gap_d;
  logic                    valid_q, valid_d, sresp_q, sresp_d, serror_q, serror_d;
  logic                    last_q, last_d;
  logic [ID_WIDTH-1:0]     sid_q, sid_d;
  logic [DATA_WIDTH-1:0]   sdata_q, sdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

  logic                    stall, full, push, pop, mem_we, wd_hs, wd_end, idx_oor;
  cmd_t                    head;
  logic [CntW-1:0]         head_len;
  logic                    ld, ld_rsvd;
  logic [IdxW-1:0]         ld_idx;
  logic [CntW-1:0]         ld_cnt, ld_len;
  logic [1:0]              ld_cmd;
  logic [ID_WIDTH-1:0]     ld_id;
  logic                    unused_addr;

`ifdef PZCOREBUS_SLAVE_BFM_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // Stall-pattern generator, reloaded with its seed on every reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign unused_addr = ^bus_io.i_maddr[OffW-1:0];
  assign full        = (count_q == (PtrW+1)'(CMD_DEPTH));
  assign head        = fifo_q[rd_ptr_q];
  // mlength of 0 stands for the maximum burst
  assign head_len    = (head.len == '0) ? {1'b1, {LENGTH_WIDTH{1'b0}}} : {1'b0, head.len};
  assign push        = bus_io.i_mcmd_valid && bus_io.o_scmd_accept;
  assign wd_hs       = bus_io.o_sdata_accept && bus_io.i_mdata_valid;
  assign wd_end      = (cnt_q == len_q - CntW'(1));
  assign idx_oor     = (idx_q >= IdxW'(MEM_WORDS));
  assign count_d     = count_q + (PtrW+1)'(push) - (PtrW+1)'(pop);

  // Accept is held low through reset and the first cycle after it
  assign bus_io.o_scmd_accept  = ready_q && !full && !stall;
  assign bus_io.o_sdata_accept = (state_q == StWriteData) && !stall;
  assign bus_io.o_sresp_valid  = valid_q;
  assign bus_io.o_sresp        = sresp_q;
  assign bus_io.o_sid          = sid_q;
  assign bus_io.o_serror       = serror_q;
  assign bus_io.o_sdata        = sdata_q;
  assign bus_io.o_sresp_last   = last_q;

  // Next-state, head capture and response-beat loading
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    id_d     = id_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    gap_d    = (gap_q != '0) ? gap_q - 16'd1 : gap_q;
    valid_d  = valid_q;
    sresp_d  = sresp_q;
    sid_d    = sid_q;
    serror_d = serror_q;
    sdata_d  = sdata_q;
    last_d   = last_q;
    pop      = 1'b0;
    mem_we   = 1'b0;
    ld       = 1'b0;
    ld_idx   = idx_q;
    ld_cnt   = cnt_q;
    ld_len   = len_q;
    ld_cmd   = cmd_q;
    ld_id    = id_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0 && gap_q == '0 && !stall) begin
          pop   = 1'b1;
          cmd_d = head.cmd;
          id_d  = head.id;
          idx_d = head.idx;
          len_d = head_len;
          cnt_d = '0;
          err_d = 1'b0;
          if (head.cmd == CmdWrite || head.cmd == CmdWnp) begin
            state_d = StWriteData;
          end else begin
            state_d = StReadResp;
            ld      = 1'b1;
            ld_idx  = head.idx;
            ld_cnt  = '0;
            ld_len  = head_len;
            ld_cmd  = head.cmd;
            ld_id   = head.id;
          end
        end
      end
      StWriteData: begin
        if (wd_hs) begin
          mem_we = !idx_oor;
          err_d  = err_q | idx_oor | (bus_io.i_mdata_last != wd_end);
          idx_d  = idx_q + IdxW'(1);
          cnt_d  = cnt_q + CntW'(1);
          if (wd_end) begin
            if (cmd_q == CmdWnp) begin
              state_d  = StWriteResp;
              valid_d  = 1'b1;
              sresp_d  = 1'b0;
              sid_d    = id_q;
              serror_d = err_d;
              sdata_d  = '0;
              last_d   = 1'b1;
            end else begin
              state_d = StIdle;
              gap_d   = 16'(RESP_GAP);
            end
          end
        end
      end
      StReadResp: begin
        if (valid_q && bus_io.i_mresp_accept) begin
          if (last_q) begin
            valid_d = 1'b0;
            state_d = StIdle;
            gap_d   = 16'(RESP_GAP);
          end else begin
            idx_d   = idx_q + IdxW'(1);
            cnt_d   = cnt_q + CntW'(1);
            ld_idx  = idx_d;
            ld_cnt  = cnt_d;
            valid_d = 1'b0;
            ld      = !stall;
          end
        end else if (!valid_q && !stall) begin
          // Beat deferred by a stall is presented now
          ld = 1'b1;
        end
      end
      StWriteResp: begin
        if (bus_io.i_mresp_accept) begin
          valid_d = 1'b0;
          state_d = StIdle;
          gap_d   = 16'(RESP_GAP);
        end
      end
      default: state_d = StIdle;
    endcase
    ld_rsvd = (ld_cmd == CmdRsvd);
    if (ld) begin
      valid_d  = 1'b1;
      sresp_d  = 1'b1;
      sid_d    = ld_id;
      last_d   = ld_rsvd || (ld_cnt == ld_len - CntW'(1));
      serror_d = ld_rsvd || (ld_idx >= IdxW'(MEM_WORDS));
      sdata_d  = ld_rsvd ? '0 : mem_q[wrap_idx(ld_idx)];
    end
  end

  // Control, FIFO pointers and registered response outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cmd_q    <= '0;
      id_q     <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      sresp_q  <= 1'b0;
      sid_q    <= '0;
      serror_q <= 1'b0;
      sdata_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= 1'b1;
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q  <= count_d;
      cmd_q    <= cmd_d;
      id_q     <= id_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      gap_q    <= gap_d;
      valid_q  <= valid_d;
      sresp_q  <= sresp_d;
      sid_q    <= sid_d;
      serror_q <= serror_d;
      sdata_q  <= sdata_d;
      last_q   <= last_d;
    end
  end

  // FIFO storage; contents need no reset since count_q gates them
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{cmd: bus_io.i_mcmd, id: bus_io.i_mid,
                            idx: bus_io.i_maddr[ADDR_WIDTH-1:OffW], len: bus_io.i_mlength};
    end
  end

  // Behavioural memory with byte-lane enables; survives reset
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (bus_io.i_mdata_byteen[b]) mem_q[wrap_idx(idx_q)][b*8 +: 8] <= bus_io.i_mdata[b*8 +: 8];
      end
    end
  end

  // Flag a master whose mdata_last disagrees with the command length
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wd_hs) begin
      assert (bus_io.i_mdata_last == wd_end)
        else $error("mdata_last %0b disagrees with beat count (end=%0b)", bus_io.i_mdata_last,
                    wd_end);
    end
  end
endmodule

// File: tb/tb_tb_pzcorebus_slave_bfm.sv
// Directed bench for the pzcorebus responder BFM.
module tb_tb_pzcorebus_slave_bfm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  tb_pzcorebus_slave_bfm_if #(
    .ID_WIDTH(8), .ADDR_WIDTH(32), .LENGTH_WIDTH(5), .DATA_WIDTH(64)
  ) bus ();

  tb_pzcorebus_slave_bfm #(
    .ID_WIDTH(8), .ADDR_WIDTH(32), .LENGTH_WIDTH(5), .DATA_WIDTH(64),
    .MEM_WORDS(1024), .CMD_DEPTH(4), .RESP_GAP(0)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus_io (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] cmd, input logic [7:0] id, input logic [31:0] addr,
                          input logic [4:0] len);
    int t;
    bus.i_mcmd_valid = 1'b1;
    bus.i_mcmd = cmd;
    bus.i_mid = id;
    bus.i_maddr = addr;
    bus.i_mlength = len;
    for (t = 0; t < 200 && !bus.o_scmd_accept; t++) step();
    if (!bus.o_scmd_accept) check("cmd_accept_timeout", bus.o_scmd_accept, 1);
    else step();
    bus.i_mcmd_valid = 1'b0;
  endtask

  task automatic send_data(input logic [63:0] data, input logic [7:0] be, input logic last);
    int t;
    bus.i_mdata_valid = 1'b1;
    bus.i_mdata = data;
    bus.i_mdata_byteen = be;
    bus.i_mdata_last = last;
    for (t = 0; t < 200 && !bus.o_sdata_accept; t++) step();
    if (!bus.o_sdata_accept) check("data_accept_timeout", bus.o_sdata_accept, 1);
    else step();
    bus.i_mdata_valid = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic sresp, input logic [7:0] sid,
                             input logic serror, input logic [63:0] sdata, input logic last);
    int t;
    bus.i_mresp_accept = 1'b1;
    for (t = 0; t < 200 && !bus.o_sresp_valid; t++) step();
    if (!bus.o_sresp_valid) begin
      check({tag, "_timeout"}, bus.o_sresp_valid, 1);
      return;
    end
    check({tag, "_sresp"}, bus.o_sresp, sresp);
    check({tag, "_sid"}, bus.o_sid, sid);
    check({tag, "_serror"}, bus.o_serror, serror);
    check({tag, "_sdata"}, bus.o_sdata, sdata);
    check({tag, "_last"}, bus.o_sresp_last, last);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_mcmd_valid = 1'b0;
    bus.i_mcmd = 2'b00;
    bus.i_mid = '0;
    bus.i_maddr = '0;
    bus.i_mlength = '0;
    bus.i_mdata_valid = 1'b0;
    bus.i_mdata = '0;
    bus.i_mdata_byteen = '0;
    bus.i_mdata_last = 1'b0;
    bus.i_mresp_accept = 1'b0;

    // Reset values
    step();
    step();
    check("rst_scmd_accept", bus.o_scmd_accept, 0);
    check("rst_sdata_accept", bus.o_sdata_accept, 0);
    check("rst_sresp_valid", bus.o_sresp_valid, 0);
    check("rst_sid", bus.o_sid, 0);
    check("rst_sdata", bus.o_sdata, 0);
    rst_n = 1'b1;
    step();
    check("post_rst_accept", bus.o_scmd_accept, 1);

    // Posted WRITE of 1..4 at 0x40 (word 8), no response expected
    send_cmd(2'b01, 8'h01, 32'h40, 5'd4);
    for (int i = 1; i <= 4; i++) send_data(64'(i), 8'hFF, i == 4);
    step();
    step();
    check("write_no_resp", bus.o_sresp_valid, 0);

    // READ it back; valid must not appear in the cycle right after acceptance
    send_cmd(2'b00, 8'h22, 32'h40, 5'd4);
    check("read_latency", bus.o_sresp_valid, 0);
    for (int i = 1; i <= 4; i++) expect_beat("rd4", 1'b1, 8'h22, 1'b0, 64'(i), i == 4);
    check("rd4_done", bus.o_sresp_valid, 0);

    // All-ones at 0x80, then WNP with low-half byte enables
    send_cmd(2'b01, 8'h02, 32'h80, 5'd1);
    send_data(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    send_cmd(2'b10, 8'h05, 32'h80, 5'd1);
    send_data(64'hAAAA_AAAA_1234_5678, 8'h0F, 1'b1);
    expect_beat("wnp", 1'b0, 8'h05, 1'b0, 64'h0, 1'b1);
    send_cmd(2'b00, 8'h06, 32'h80, 5'd1);
    expect_beat("wnp_rb", 1'b1, 8'h06, 1'b0, 64'hFFFF_FFFF_1234_5678, 1'b1);

    // Back-pressure: one command is taken into the FSM, four more fill the FIFO
    bus.i_mresp_accept = 1'b0;
    for (int i = 0; i < 5; i++) send_cmd(2'b00, 8'(10 + i), 32'(32'h40 + 8 * (i % 4)), 5'd1);
    check("bp_full_accept", bus.o_scmd_accept, 0);
    step();
    step();
    check("bp_hold_valid", bus.o_sresp_valid, 1);
    check("bp_hold_sid", bus.o_sid, 10);
    check("bp_hold_data", bus.o_sdata, 1);
    for (int i = 0; i < 5; i++)
      expect_beat("bp_drain", 1'b1, 8'(10 + i), 1'b0, 64'((i % 4) + 1), 1'b1);

    // Top-of-memory read: second beat is out of range and wraps to word 0
    send_cmd(2'b01, 8'h07, 32'h1FF8, 5'd1);
    send_data(64'hDEAD, 8'hFF, 1'b1);
    send_cmd(2'b01, 8'h08, 32'h0, 5'd1);
    send_data(64'hBEEF, 8'hFF, 1'b1);
    send_cmd(2'b00, 8'h09, 32'h1FF8, 5'd2);
    expect_beat("edge_b0", 1'b1, 8'h09, 1'b0, 64'hDEAD, 1'b0);
    expect_beat("edge_b1", 1'b1, 8'h09, 1'b1, 64'hBEEF, 1'b1);

    // Reserved command
    send_cmd(2'b11, 8'h03, 32'h40, 5'd1);
    expect_beat("rsvd", 1'b1, 8'h03, 1'b1, 64'h0, 1'b1);
    check("rsvd_single", bus.o_sresp_valid, 0);

    // Reset in the middle of a read burst
    send_cmd(2'b00, 8'h77, 32'h40, 5'd4);
    expect_beat("mid_b0", 1'b1, 8'h77, 1'b0, 64'h1, 1'b0);
    bus.i_mresp_accept = 1'b0;
    check("mid_valid_before", bus.o_sresp_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.o_sresp_valid, 0);
    check("mid_rst_accept", bus.o_scmd_accept, 0);
    step();
    rst_n = 1'b1;
    step();
    send_cmd(2'b00, 8'h78, 32'h48, 5'd1);
    expect_beat("post_rst_rd", 1'b1, 8'h78, 1'b0, 64'h2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
